// File: rtl/camlink_axis_packer.sv
// CameraLink (FVAL/LVAL/DVAL + TAPS pixel ports) to AXI4-Stream packer with elastic output FIFO.
// Optional per-line/per-frame statistics outputs are enabled with `define CAM_AXIS_STATS_EN.
module camlink_axis_packer #(
  parameter int TAPS       = 3,
  parameter int TAP_WIDTH  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_WIDTH = TAPS * TAP_WIDTH
) (
  input  logic                          axis_clk,
  input  logic                          rst,
  input  logic                          in_fval,
  input  logic                          in_lval,
  input  logic                          in_dval,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef CAM_AXIS_STATS_EN
  ,
  output logic [15:0]                   line_pixels,
  output logic [15:0]                   frame_lines,
  output logic [15:0]                   frame_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_SOF, S_ACTIVE, S_DROP} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_fval_p0, r_lval_p0, r_dval_p0;
  logic                  r_fval_p1, r_lval_p1;
  logic [DATA_WIDTH-1:0] r_data_p0;
  logic                  w_fval_rise, w_fval_fall, w_lval_fall, w_pix;
  logic                  w_accept_en, w_sof, w_active;
  logic                  w_accept, w_end;
  logic                  r_hold_vld, r_hold_first, r_first;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic                  w_push_req, w_push_ok, w_pop, w_full, w_ovf;
  logic [DATA_WIDTH+1:0] r_mem [FIFO_DEPTH];
  logic [DATA_WIDTH+1:0] w_head;
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [AW:0]           r_count;
  logic                  r_ovf;

  // Stage 0: register the CameraLink timing and pixels. fval resets high so that
  // IDLE only leaves once a genuinely low fval has been sampled.
  always_ff @(posedge axis_clk or posedge rst) begin
    if (rst) begin
      r_fval_p0 <= 1'b1;
      r_fval_p1 <= 1'b1;
      r_lval_p0 <= 1'b0;
      r_lval_p1 <= 1'b0;
      r_dval_p0 <= 1'b0;
    end else begin
      r_fval_p0 <= in_fval;
      r_lval_p0 <= in_lval;
      r_dval_p0 <= in_dval;
      r_fval_p1 <= r_fval_p0;
      r_lval_p1 <= r_lval_p0;
    end
  end

  always_ff @(posedge axis_clk) begin
    r_data_p0 <= in_data;
  end

  assign w_fval_rise = r_fval_p0 & ~r_fval_p1;
  assign w_fval_fall = ~r_fval_p0 & r_fval_p1;
  assign w_lval_fall = ~r_lval_p0 & r_lval_p1;
  assign w_pix       = r_fval_p0 & r_lval_p0 & r_dval_p0;

  // Stage 1: framing FSM.
  always_ff @(posedge axis_clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (!r_fval_p0) w_state_next = S_WAIT_SOF;
      S_WAIT_SOF: if (w_fval_rise) w_state_next = S_ACTIVE;
      S_ACTIVE: begin
        if (w_ovf)            w_state_next = S_DROP;
        else if (w_fval_fall) w_state_next = S_WAIT_SOF;
      end
      S_DROP:     if (!r_fval_p0) w_state_next = S_WAIT_SOF;
      default:    w_state_next = S_IDLE;
    endcase
  end

  // A pixel arriving in the same cycle as the fval rising edge belongs to the new frame.
  always_comb begin
    w_accept_en = 1'b0;
    w_sof       = 1'b0;
    w_active    = 1'b0;
    case (r_state)
      S_WAIT_SOF: begin
        w_sof       = w_fval_rise;
        w_accept_en = w_fval_rise;
      end
      S_ACTIVE: begin
        w_active    = 1'b1;
        w_accept_en = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_accept   = w_pix & w_accept_en;
  assign w_end      = w_active & (w_lval_fall | w_fval_fall);
  assign w_push_req = r_hold_vld & (w_accept | w_end);
  assign w_pop      = m_axis_tvalid & m_axis_tready;
  assign w_full     = (r_count == DEPTH_C);
  assign w_push_ok  = w_push_req & (~w_full | w_pop);
  assign w_ovf      = w_push_req & ~w_push_ok;

  // Hold register delays each word by one pixel so tlast is known when it is pushed.
  always_ff @(posedge axis_clk or posedge rst) begin
    if (rst) begin
      r_hold_vld   <= 1'b0;
      r_hold_first <= 1'b0;
      r_first      <= 1'b0;
    end else begin
      if (w_ovf) begin
        r_hold_vld <= 1'b0;
      end else if (w_accept) begin
        r_hold_vld   <= 1'b1;
        r_hold_first <= r_first | w_sof;
      end else if (w_end) begin
        r_hold_vld <= 1'b0;
      end
      if (w_sof)         r_first <= ~w_accept;
      else if (w_accept) r_first <= 1'b0;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (w_accept) r_hold_data <= r_data_p0;
  end

  // Stage 2: first-word-fall-through FIFO; entry = {user, last, data}.
  always_ff @(posedge axis_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= {r_hold_first, w_end, r_hold_data};
  end

  always_ff @(posedge axis_clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_ovf <= w_ovf;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push_ok && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (!w_push_ok && w_pop) r_count <= r_count - CNT_ONE;
    end
  end

  assign w_head        = r_mem[r_rd_ptr];
  assign m_axis_tvalid = (r_count != '0);
  assign m_axis_tdata  = m_axis_tvalid ? w_head[DATA_WIDTH-1:0] : '0;
  assign m_axis_tlast  = m_axis_tvalid & w_head[DATA_WIDTH];
  assign m_axis_tuser  = m_axis_tvalid & w_head[DATA_WIDTH+1];
  assign overflow      = r_ovf;
  assign fifo_level    = r_count;

`ifdef CAM_AXIS_STATS_EN
  logic [15:0] r_line_cnt, r_lines_cnt;
  logic [15:0] r_line_pixels, r_frame_lines, r_frame_count;
  logic [15:0] w_lines_next;
  logic        w_line_done, w_frame_done;

  // A line also ends when fval drops while lval is still high.
  assign w_line_done  = w_active & (w_lval_fall | (w_fval_fall & r_lval_p1));
  assign w_frame_done = w_active & w_fval_fall & ~w_ovf;
  assign w_lines_next = (w_line_done && r_line_cnt != 16'd0) ? sat_inc16(r_lines_cnt) : r_lines_cnt;

  always_ff @(posedge axis_clk or posedge rst) begin
    if (rst) begin
      r_line_cnt    <= '0;
      r_lines_cnt   <= '0;
      r_line_pixels <= '0;
      r_frame_lines <= '0;
      r_frame_count <= '0;
    end else begin
      if (w_line_done)           r_line_cnt <= '0;
      else if (w_accept)         r_line_cnt <= sat_inc16(r_line_cnt);
      else if (!w_active)        r_line_cnt <= '0;
      if (w_frame_done || !w_active) r_lines_cnt <= '0;
      else                           r_lines_cnt <= w_lines_next;
      if (w_line_done) r_line_pixels <= r_line_cnt;
      if (w_frame_done) begin
        r_frame_lines <= w_lines_next;
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  assign line_pixels = r_line_pixels;
  assign frame_lines = r_frame_lines;
  assign frame_count = r_frame_count;
`endif

endmodule
